// File: rtl/uart_tx_fifo_reader_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, default baud divisor
// and the parity helper. Imported by the TX reader and reused by the receiver.
package uart_tx_fifo_reader_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 868;   // 100 MHz / 115200

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5,
      ST_STOP   = 3'd6
   } uart_state_t;

   // Caller zero-extends narrow words; extra zero bits leave the parity unchanged.
   function automatic logic calc_parity(input logic [7:0] data, input int mode);
      logic p;
      p = 1'b0;
      case (mode)
         PARITY_EVEN: p = ^data;
         PARITY_ODD:  p = ~^data;
         PARITY_NONE: p = 1'b0;
         default:     p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and wraps; bit_tick on the last count,
// bit_tick_early one cycle before it. clear holds the count at zero (no backpressure).
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_tick,
   output logic bit_tick_early
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear || count == LAST_CNT) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   assign bit_tick       = (count == LAST_CNT);
   assign bit_tick_early = (count == PRE_CNT);

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from a registered-output FIFO and serialises them.
// Pop-to-start-bit latency 2 cycles; new frames start only when enable is high and the FIFO is non-empty.
module uart_tx_fifo_reader
   import uart_tx_fifo_reader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = PARITY_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [DATA_BITS-1:0] fifo_data,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int IDX_W = $clog2(DATA_BITS) + 1;
   localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);
   localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);

   uart_state_t          state;
   logic [DATA_BITS-1:0] shreg;
   logic [IDX_W-1:0]     bit_idx;
   logic                 parity_bit;
   logic                 baud_clear;
   logic                 bit_tick;
   logic                 bit_tick_early;

   // Hold the divider at zero until the start bit so every bit period is full length.
   assign baud_clear = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_LOAD);

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk           (clk),
      .rst           (rst),
      .clear         (baud_clear),
      .bit_tick      (bit_tick),
      .bit_tick_early(bit_tick_early)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         tx         <= 1'b1;
         fifo_rd_en <= 1'b0;
         busy       <= 1'b0;
         tx_done    <= 1'b0;
         shreg      <= '0;
         bit_idx    <= '0;
         parity_bit <= 1'b0;
      end else begin
         fifo_rd_en <= 1'b0;
         tx_done    <= 1'b0;
         case (state)
            ST_IDLE: begin
               tx <= 1'b1;
               if (enable && !fifo_empty) begin
                  state      <= ST_FETCH;
                  fifo_rd_en <= 1'b1;
                  busy       <= 1'b1;
               end
            end

            ST_FETCH: begin
               state <= ST_LOAD;
            end

            // FIFO data_out is registered, so the popped word is valid only now.
            ST_LOAD: begin
               shreg      <= fifo_data;
               parity_bit <= calc_parity(8'(fifo_data), PARITY_MODE);
               tx         <= 1'b0;
               state      <= ST_START;
            end

            ST_START: begin
               if (bit_tick) begin
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end
            end

            ST_DATA: begin
               if (bit_tick) begin
                  if (bit_idx == LAST_DATA_IDX) begin
                     bit_idx <= '0;
                     if (HAS_PARITY) begin
                        tx    <= parity_bit;
                        state <= ST_PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                     end
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end
            end

            ST_PARITY: begin
               if (bit_tick) begin
                  tx      <= 1'b1;
                  bit_idx <= '0;
                  state   <= ST_STOP;
               end
            end

            // tx_done is registered, so it is launched one count early to land on the last cycle.
            ST_STOP: begin
               if (bit_tick_early && bit_idx == LAST_STOP_IDX) begin
                  tx_done <= 1'b1;
               end
               if (bit_tick) begin
                  if (bit_idx == LAST_STOP_IDX) begin
                     bit_idx <= '0;
                     busy    <= 1'b0;
                     state   <= ST_IDLE;
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end
            end

            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
